// File: rtl/hazard_unit.sv
// Pipeline interlock between ID and EX. It covers load-use hazards against EX and mul/div RAW and structural hazards, using a per-register scoreboard.
// Latency: the stall/bubble outputs are combinational from the ID/EX inputs and registered state; pending, busy and the stall counter are registered.
// Backpressure: it holds IF/ID and injects an ID/EX bubble while any hazard term is live. A flush overrides the stall in the same cycle.
//
// Ports:
//   i_clk, i_rst                      clock, asynchronous active-high reset
//   i_id_*                            instruction currently in ID (valid, sources, mul/div flag)
//   i_ex_rd, i_ex_is_load             instruction currently in EX
//   i_md_issue[_rd], i_md_done[_rd]   mul/div unit accept / writeback events
//   i_flush                           redirect; kills IF/ID and ID/EX
//   o_stall_if, o_bubble_ex           interlock controls (always equal)
//   o_pending                         scoreboard, bit n = x(n) awaiting a mul/div result
//   o_md_busy                         mul/div unit holds MD_MAX_OUTSTANDING operations
//   o_stall_count                     saturating count of stalled cycles
module hazard_unit #(
    parameter int MD_MAX_OUTSTANDING = 1,
    parameter int CNT_WIDTH          = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_id_valid,
    input  logic [4:0]           i_id_rs1,
    input  logic [4:0]           i_id_rs2,
    input  logic                 i_id_uses_rs1,
    input  logic                 i_id_uses_rs2,
    input  logic                 i_id_is_md,
    input  logic [4:0]           i_ex_rd,
    input  logic                 i_ex_is_load,
    input  logic                 i_md_issue,
    input  logic [4:0]           i_md_issue_rd,
    input  logic                 i_md_done,
    input  logic [4:0]           i_md_done_rd,
    input  logic                 i_flush,
    output logic                 o_stall_if,
    output logic                 o_bubble_ex,
    output logic [31:0]          o_pending,
    output logic                 o_md_busy,
    output logic [CNT_WIDTH-1:0] o_stall_count
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_STALL = 2'd1,
        MD_WAIT    = 2'd2
    } state_t;

    localparam logic [2:0]           MD_MAX    = 3'(MD_MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0] CNT_ALL_1 = '1;

    state_t                 state;
    state_t                 state_next;
    logic [31:0]            pending;
    logic [31:0]            pending_next;
    logic [2:0]             md_count;
    logic [2:0]             md_count_next;
    logic [CNT_WIDTH-1:0]   stall_count;

    logic rs1_live;
    logic rs2_live;
    logic load_use;
    logic sb_hit;
    logic md_struct;
    logic md_busy;
    logic stall_any;
    logic stall;

    // A source only matters if ID is valid, the operand is really read,
    // and it is not x0 (x0 is never produced by anybody).
    assign rs1_live = i_id_valid & i_id_uses_rs1 & (i_id_rs1 != 5'd0);
    assign rs2_live = i_id_valid & i_id_uses_rs2 & (i_id_rs2 != 5'd0);

    assign md_busy = (md_count == MD_MAX);

    assign load_use = i_ex_is_load & (i_ex_rd != 5'd0) &
                      ((rs1_live & (i_id_rs1 == i_ex_rd)) |
                       (rs2_live & (i_id_rs2 == i_ex_rd)));

    // The registered scoreboard is used on purpose. A result written back this
    // cycle reaches the bypass only next cycle, so a same-cycle completion still stalls.
    assign sb_hit = (rs1_live & pending[i_id_rs1]) |
                    (rs2_live & pending[i_id_rs2]);

    assign md_struct = i_id_valid & i_id_is_md & md_busy;

    assign stall_any = load_use | sb_hit | md_struct;
    assign stall     = stall_any & ~i_flush;

    assign o_stall_if    = stall;
    assign o_bubble_ex   = stall;
    assign o_pending     = pending;
    assign o_md_busy     = md_busy;
    assign o_stall_count = stall_count;

    // Scoreboard update. The clear is applied first so that a same-register issue,
    // which is a younger producer, wins.
    always_comb begin
        pending_next = pending;
        if (i_md_done) begin
            pending_next[i_md_done_rd] = 1'b0;
        end
        if (i_md_issue && (i_md_issue_rd != 5'd0)) begin
            pending_next[i_md_issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Outstanding mul/div operations. Illegal overflow and underflow are caught by
    // the assertions below; in hardware the count is clamped.
    always_comb begin
        md_count_next = md_count;
        if (i_md_issue && !i_md_done) begin
            if (!md_busy) begin
                md_count_next = md_count + 3'd1;
            end
        end else if (i_md_done && !i_md_issue) begin
            if (md_count != 3'd0) begin
                md_count_next = md_count - 3'd1;
            end
        end
    end

    // Observability FSM; it does not feed the stall outputs.
    always_comb begin
        state_next = state;
        if (i_flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (load_use) begin
                        state_next = LOAD_STALL;
                    end else if (sb_hit || md_struct) begin
                        state_next = MD_WAIT;
                    end
                end
                LOAD_STALL: begin
                    // The load has reached MEM and is forwardable after one bubble.
                    if (sb_hit || md_struct) begin
                        state_next = MD_WAIT;
                    end else begin
                        state_next = IDLE;
                    end
                end
                MD_WAIT: begin
                    if (!stall_any) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            pending     <= 32'd0;
            md_count    <= 3'd0;
            stall_count <= '0;
        end else begin
            state    <= state_next;
            pending  <= pending_next;
            md_count <= md_count_next;
            if (stall && (stall_count != CNT_ALL_1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    // The mul/div unit must not accept beyond capacity or complete when empty.
    a_md_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_md_issue && !i_md_done && md_busy));
    a_md_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_md_done && !i_md_issue && (md_count == 3'd0)));
    a_x0_never_pending: assert property (@(posedge i_clk) disable iff (i_rst)
        !pending[0]);
    a_count_in_range: assert property (@(posedge i_clk) disable iff (i_rst)
        md_count <= MD_MAX);
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Testbench for hazard_unit. It runs directed scenarios with fixed expectations,
// followed by randomized traffic checked against a behavioural reference model.
// It uses a narrow stall counter so that counter saturation can be reached.
module tb_hazard_unit;
    localparam int MAX  = 1;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int S_IDLE = 0, S_LOAD = 1, S_MD = 2;

    logic          clk, rst;
    logic          id_valid, uses1, uses2, id_is_md, ex_is_load;
    logic [4:0]    id_rs1, id_rs2, ex_rd, md_issue_rd, md_done_rd;
    logic          md_issue, md_done, flush;
    logic          stall_if, bubble_ex, md_busy;
    logic [31:0]   pending;
    logic [CW-1:0] stall_count;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [31:0] m_pend;
    int          m_out;
    int          m_cnt;
    int          m_state;

    hazard_unit #(.MD_MAX_OUTSTANDING(MAX), .CNT_WIDTH(CW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_uses_rs1(uses1), .i_id_uses_rs2(uses2), .i_id_is_md(id_is_md),
        .i_ex_rd(ex_rd), .i_ex_is_load(ex_is_load),
        .i_md_issue(md_issue), .i_md_issue_rd(md_issue_rd),
        .i_md_done(md_done), .i_md_done_rd(md_done_rd), .i_flush(flush),
        .o_stall_if(stall_if), .o_bubble_ex(bubble_ex), .o_pending(pending),
        .o_md_busy(md_busy), .o_stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit src_live(input logic [4:0] r, input logic u);
        return id_valid && u && (r != 5'd0);
    endfunction

    function automatic bit m_load_use();
        return ex_is_load && (ex_rd != 5'd0) &&
               ((src_live(id_rs1, uses1) && id_rs1 == ex_rd) ||
                (src_live(id_rs2, uses2) && id_rs2 == ex_rd));
    endfunction

    function automatic bit m_sb_hit();
        return (src_live(id_rs1, uses1) && m_pend[id_rs1]) ||
               (src_live(id_rs2, uses2) && m_pend[id_rs2]);
    endfunction

    function automatic bit m_md_struct();
        return id_valid && id_is_md && (m_out == MAX);
    endfunction

    function automatic bit m_stall();
        return (m_load_use() || m_sb_hit() || m_md_struct()) && !flush;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend  <= '0;
            m_out   <= 0;
            m_cnt   <= 0;
            m_state <= S_IDLE;
        end else begin
            for (int n = 0; n < 32; n++) begin
                if (md_issue && int'(md_issue_rd) == n && n != 0) m_pend[n] <= 1'b1;
                else if (md_done && int'(md_done_rd) == n)       m_pend[n] <= 1'b0;
            end
            if (md_issue && !md_done)      m_out <= (m_out < MAX) ? m_out + 1 : m_out;
            else if (md_done && !md_issue) m_out <= (m_out > 0) ? m_out - 1 : 0;
            if (m_stall() && m_cnt < CMAX) m_cnt <= m_cnt + 1;
            if (flush)                   m_state <= S_IDLE;
            else if (m_state == S_IDLE)  m_state <= m_load_use() ? S_LOAD :
                                                    (m_sb_hit() || m_md_struct()) ? S_MD : S_IDLE;
            else if (m_state == S_LOAD)  m_state <= (m_sb_hit() || m_md_struct()) ? S_MD : S_IDLE;
            else                         m_state <= (m_load_use() || m_sb_hit() || m_md_struct()) ? S_MD : S_IDLE;
        end
    end

    task automatic idle_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; uses1 = 0; uses2 = 0; id_is_md = 0;
        ex_rd = 0; ex_is_load = 0; md_issue = 0; md_issue_rd = 0;
        md_done = 0; md_done_rd = 0; flush = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1;
        next_cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 0;
        #1 rst = 1;
        #1;
        checks += 6;
        if (pending !== 32'd0) begin errors++; $display("FAIL reset_pending got=%h want=0", pending); end
        if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", md_busy); end
        if (stall_count !== '0) begin errors++; $display("FAIL reset_count got=%0d want=0", stall_count); end
        if (stall_if !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", stall_if); end
        if (bubble_ex !== 1'b0) begin errors++; $display("FAIL reset_bubble got=%b want=0", bubble_ex); end
        if (int'(dut.state) !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d want=0", int'(dut.state)); end
        next_cycle();
        rst = 0;
    endtask

    task automatic test_load_use();
        reset_dut();
        // EX: lw x5 ; ID: add x6, x5, x1
        id_valid = 1; id_rs1 = 5; uses1 = 1; id_rs2 = 1; uses2 = 1;
        ex_is_load = 1; ex_rd = 5;
        @(negedge clk);
        checks += 3;
        if (stall_if !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b want=1", stall_if); end
        if (bubble_ex !== 1'b1) begin errors++; $display("FAIL lu_bubble got=%b want=1", bubble_ex); end
        if (int'(dut.state) !== S_IDLE) begin errors++; $display("FAIL lu_state0 got=%0d want=0", int'(dut.state)); end
        next_cycle();
        ex_is_load = 0; ex_rd = 0;   // bubble now in EX
        @(negedge clk);
        checks += 3;
        if (stall_if !== 1'b0) begin errors++; $display("FAIL lu_release got=%b want=0", stall_if); end
        if (stall_count !== 4'd1) begin errors++; $display("FAIL lu_count got=%0d want=1", stall_count); end
        if (int'(dut.state) !== S_LOAD) begin errors++; $display("FAIL lu_state1 got=%0d want=1", int'(dut.state)); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks += 2;
        if (int'(dut.state) !== S_IDLE) begin errors++; $display("FAIL lu_state2 got=%0d want=0", int'(dut.state)); end
        if (stall_count !== 4'd1) begin errors++; $display("FAIL lu_count2 got=%0d want=1", stall_count); end
    endtask

    task automatic test_load_qualifiers();
        reset_dut();
        // load to x0 with ID reading x0
        ex_is_load = 1; ex_rd = 0; id_valid = 1; id_rs1 = 0; uses1 = 1; id_rs2 = 0; uses2 = 1;
        @(negedge clk);
        checks++;
        if (stall_if !== 1'b0) begin errors++; $display("FAIL lx0_stall got=%b want=0", stall_if); end
        // matching register but not actually read
        ex_rd = 5; id_rs1 = 5; uses1 = 0; id_rs2 = 5; uses2 = 0;
        #1;
        checks++;
        if (stall_if !== 1'b0) begin errors++; $display("FAIL lunused_stall got=%b want=0", stall_if); end
        // match through rs2 only
        uses2 = 1;
        #1;
        checks++;
        if (stall_if !== 1'b1) begin errors++; $display("FAIL lrs2_stall got=%b want=1", stall_if); end
        // invalid ID instruction
        id_valid = 0;
        #1;
        checks++;
        if (stall_if !== 1'b0) begin errors++; $display("FAIL linvalid_stall got=%b want=0", stall_if); end
        idle_inputs();
    endtask

    task automatic test_scoreboard();
        reset_dut();
        for (int k = 0; k <= 6; k++) begin
            md_issue = (k == 0); md_issue_rd = 7;
            md_done = (k == 4);  md_done_rd = 7;
            id_valid = (k >= 1); id_rs1 = 7; uses1 = 1;
            @(negedge clk);
            checks += 4;
            if (stall_if !== (k >= 1 && k <= 4)) begin errors++; $display("FAIL sb_stall k=%0d got=%b", k, stall_if); end
            if (pending[7] !== (k >= 1 && k <= 4)) begin errors++; $display("FAIL sb_pend7 k=%0d got=%b", k, pending[7]); end
            if (int'(stall_count) !== ((k >= 2) ? ((k > 5) ? 4 : k - 1) : 0)) begin
                errors++; $display("FAIL sb_count k=%0d got=%0d", k, stall_count);
            end
            if (int'(dut.state) !== ((k >= 2 && k <= 5) ? S_MD : S_IDLE)) begin
                errors++; $display("FAIL sb_state k=%0d got=%0d", k, int'(dut.state));
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_same_cycle_set_clear();
        reset_dut();
        for (int k = 0; k <= 3; k++) begin
            md_issue = (k <= 1); md_issue_rd = 9;
            md_done = (k == 1 || k == 2); md_done_rd = 9;
            @(negedge clk);
            checks += 2;
            if (pending[9] !== (k >= 1 && k <= 2)) begin errors++; $display("FAIL sc_pend9 k=%0d got=%b", k, pending[9]); end
            if (md_busy !== (k >= 1 && k <= 2)) begin errors++; $display("FAIL sc_busy k=%0d got=%b", k, md_busy); end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_structural();
        reset_dut();
        for (int k = 0; k <= 4; k++) begin
            md_issue = (k == 0); md_issue_rd = 3;
            md_done = (k == 3);  md_done_rd = 3;
            id_valid = (k >= 1); id_is_md = 1; id_rs1 = 3; uses1 = 0;
            @(negedge clk);
            checks += 2;
            if (stall_if !== (k >= 1 && k <= 3)) begin errors++; $display("FAIL st_stall k=%0d got=%b", k, stall_if); end
            if (md_busy !== (k >= 1 && k <= 3)) begin errors++; $display("FAIL st_busy k=%0d got=%b", k, md_busy); end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_flush_and_async_reset();
        reset_dut();
        md_issue = 1; md_issue_rd = 7;
        next_cycle();
        md_issue = 0; id_valid = 1; id_rs1 = 7; uses1 = 1;
        @(negedge clk);
        checks++;
        if (stall_if !== 1'b1) begin errors++; $display("FAIL fl_stall1 got=%b want=1", stall_if); end
        next_cycle();
        flush = 1;
        @(negedge clk);
        checks += 2;
        if (stall_if !== 1'b0) begin errors++; $display("FAIL fl_stall_drop got=%b want=0", stall_if); end
        if (int'(dut.state) !== S_MD) begin errors++; $display("FAIL fl_state_pre got=%0d want=2", int'(dut.state)); end
        next_cycle();
        flush = 0;
        @(negedge clk);
        checks += 2;
        if (int'(dut.state) !== S_IDLE) begin errors++; $display("FAIL fl_state_idle got=%0d want=0", int'(dut.state)); end
        if (stall_if !== 1'b1) begin errors++; $display("FAIL fl_restall got=%b want=1", stall_if); end
        next_cycle();
        #2 rst = 1;
        #1;
        checks += 5;
        if (pending !== 32'd0) begin errors++; $display("FAIL ar_pending got=%h want=0", pending); end
        if (md_busy !== 1'b0) begin errors++; $display("FAIL ar_busy got=%b want=0", md_busy); end
        if (stall_count !== '0) begin errors++; $display("FAIL ar_count got=%0d want=0", stall_count); end
        if (stall_if !== 1'b0) begin errors++; $display("FAIL ar_stall got=%b want=0", stall_if); end
        if (int'(dut.state) !== S_IDLE) begin errors++; $display("FAIL ar_state got=%0d want=0", int'(dut.state)); end
        next_cycle();
        rst = 0;
        @(negedge clk);
        checks++;
        if (stall_if !== 1'b0) begin errors++; $display("FAIL ar_first_cycle got=%b want=0", stall_if); end
        idle_inputs();
    endtask

    task automatic test_count_saturation();
        reset_dut();
        id_valid = 1; id_rs1 = 4; uses1 = 1; ex_is_load = 1; ex_rd = 4;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (int'(stall_count) !== ((k < CMAX) ? k : CMAX)) begin
                errors++; $display("FAIL sat_count k=%0d got=%0d", k, stall_count);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int q[$];
        reset_dut();
        q.delete();
        for (int i = 0; i < 600; i++) begin
            idle_inputs();
            rst = ((i % 97) == 96);
            id_valid   = ($urandom_range(0, 3) != 0);
            id_rs1     = 5'($urandom_range(0, 7));
            id_rs2     = 5'($urandom_range(0, 7));
            uses1      = 1'($urandom_range(0, 1));
            uses2      = 1'($urandom_range(0, 1));
            id_is_md   = ($urandom_range(0, 3) == 0);
            ex_is_load = ($urandom_range(0, 2) == 0);
            ex_rd      = 5'($urandom_range(0, 7));
            flush      = ($urandom_range(0, 15) == 0);
            if (rst) begin
                q.delete();
            end else begin
                if (m_out > 0 && $urandom_range(0, 2) == 0) begin
                    md_done = 1;
                    md_done_rd = 5'(q.pop_front());
                end
                if ((m_out - int'(md_done)) < MAX && $urandom_range(0, 2) == 0) begin
                    md_issue = 1;
                    md_issue_rd = 5'($urandom_range(0, 7));
                    q.push_back(int'(md_issue_rd));
                end
            end
            @(negedge clk);
            checks += 6;
            if (stall_if !== m_stall()) begin errors++; $display("FAIL rnd_stall i=%0d got=%b want=%b", i, stall_if, m_stall()); end
            if (bubble_ex !== m_stall()) begin errors++; $display("FAIL rnd_bubble i=%0d got=%b want=%b", i, bubble_ex, m_stall()); end
            if (pending !== m_pend) begin errors++; $display("FAIL rnd_pending i=%0d got=%h want=%h", i, pending, m_pend); end
            if (md_busy !== (m_out == MAX)) begin errors++; $display("FAIL rnd_busy i=%0d got=%b want=%b", i, md_busy, m_out == MAX); end
            if (int'(stall_count) !== m_cnt) begin errors++; $display("FAIL rnd_count i=%0d got=%0d want=%0d", i, stall_count, m_cnt); end
            if (int'(dut.state) !== m_state) begin errors++; $display("FAIL rnd_state i=%0d got=%0d want=%0d", i, int'(dut.state), m_state); end
            next_cycle();
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        test_reset();
        test_load_use();
        test_load_qualifiers();
        test_scoreboard();
        test_same_cycle_set_clear();
        test_structural();
        test_flush_and_async_reset();
        test_count_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
